// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, the NOP word and the default reset PC.
package pc_fetch_unit_pkg;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register: sync reset to RESET_PC, redirect load has priority over sequential increment.
module pc_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_pc,
  input  logic                  inc,
  output logic [DATA_WIDTH-1:0] pc
);

  logic [DATA_WIDTH-1:0] pc_reg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg_q <= RESET_PC;
    end else if (load) begin
      pc_reg_q <= load_pc;
    end else if (inc) begin
      // Natural modulo-2^W wrap at the top of the address space.
      pc_reg_q <= pc_reg_q + DATA_WIDTH'(PC_STEP);
    end
  end

  assign pc = pc_reg_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, one-outstanding imem req/ack handshake and a 1-entry output register.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect reported via if_misalign).
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  input  logic                  if_ready
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                  if_misalign
`endif
);

  fetch_state_e          state_reg, state_next;
  logic                  pending_reg, pending_next;
  logic [DATA_WIDTH-1:0] addr_hold_reg;
  logic                  if_valid_reg, if_valid_next;
  logic [DATA_WIDTH-1:0] if_pc_reg, if_pc_next;
  logic [DATA_WIDTH-1:0] if_instr_reg, if_instr_next;
  logic [DATA_WIDTH-1:0] pc, load_pc;
  logic                  pc_inc;
  logic                  issue_ok, transfer, ack_take;
  logic                  block_fetch, fill;

  pc_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .RESET_PC  (RESET_PC),
    .PC_STEP   (PC_STEP)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (redirect_valid),
    .load_pc(load_pc),
    .inc    (pc_inc),
    .pc     (pc)
  );

  assign issue_ok = !if_valid_reg | if_ready;
  assign transfer = if_valid_reg & if_ready;

  // An outstanding request is never dropped (only rst abandons it), so pending/drain keep req asserted.
  assign imem_req = !rst & (pending_reg | (state_reg == S_DRAIN) |
                            ((state_reg == S_FETCH) & issue_ok & !redirect_valid & !block_fetch));
  // While waiting for an ack, present the address of the original request even if pc was redirected.
  assign imem_addr = pending_reg ? addr_hold_reg : pc;
  assign ack_take  = imem_req & imem_ack;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_pend_reg, fill_done_reg, misalign_reg;

  assign load_pc     = redirect_pc;
  assign block_fetch = mis_pend_reg;
  assign fill        = mis_pend_reg & !fill_done_reg & (state_reg == S_FETCH) & issue_ok & !redirect_valid;
  assign if_misalign = misalign_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_pend_reg  <= 1'b0;
      fill_done_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else if (redirect_valid) begin
      mis_pend_reg  <= (redirect_pc[1:0] != 2'b00);
      fill_done_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else if (fill) begin
      fill_done_reg <= 1'b1;
      misalign_reg  <= 1'b1;
    end else if (transfer) begin
      misalign_reg  <= 1'b0;
    end
  end
`else
  assign load_pc     = redirect_pc & ~DATA_WIDTH'(3);
  assign block_fetch = 1'b0;
  assign fill        = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    pending_next  = imem_req & !imem_ack;
    if_valid_next = if_valid_reg;
    if_pc_next    = if_pc_reg;
    if_instr_next = if_instr_reg;
    pc_inc        = 1'b0;
    if (redirect_valid) begin
      if_valid_next = 1'b0;
      state_next    = (pending_reg & !ack_take) ? S_DRAIN : S_FETCH;
    end else if (state_reg == S_DRAIN) begin
      if (ack_take) state_next = S_FETCH;
      if (transfer) if_valid_next = 1'b0;
    end else if (ack_take) begin
      if_valid_next = 1'b1;
      if_pc_next    = pc;
      if_instr_next = imem_rdata;
      pc_inc        = 1'b1;
    end else if (fill) begin
      if_valid_next = 1'b1;
      if_pc_next    = pc;
      if_instr_next = DATA_WIDTH'(NOP_INSTR);
    end else if (transfer) begin
      if_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_FETCH;
      pending_reg   <= 1'b0;
      addr_hold_reg <= '0;
      if_valid_reg  <= 1'b0;
      if_pc_reg     <= '0;
      if_instr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      addr_hold_reg <= imem_addr;
      if_valid_reg  <= if_valid_next;
      if_pc_reg     <= if_pc_next;
      if_instr_reg  <= if_instr_next;
    end
  end

  assign if_valid = if_valid_reg;
  assign if_pc    = if_pc_reg;
  assign if_instr = if_instr_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, stalls, delayed ack, redirect/drain, wrap and reset.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  int checks   = 0;
  int failures = 0;

  pc_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_ready      (if_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // Advance one clock; registered outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    step(); step();
    settle();
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);

    // 1: same-cycle ack, one fetch per cycle, if_pc trails imem_addr by one cycle
    rst = 1'b0; imem_ack = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 32'h1111_0000 + 32'(i * 4);
      settle();
      check_eq($sformatf("seq_req%0d", i), {31'd0, imem_req}, 32'd1);
      check_eq($sformatf("seq_addr%0d", i), imem_addr, 32'(i * 4));
      step();
      check_eq($sformatf("seq_valid%0d", i), {31'd0, if_valid}, 32'd1);
      check_eq($sformatf("seq_if_pc%0d", i), if_pc, 32'(i * 4));
      check_eq($sformatf("seq_instr%0d", i), if_instr, 32'h1111_0000 + 32'(i * 4));
    end

    // 2: back-pressure holds the output and suppresses requests
    if_ready = 1'b0; imem_ack = 1'b0;
    settle();
    check_eq("bp_req", {31'd0, imem_req}, 32'd0);
    step();
    check_eq("bp_valid", {31'd0, if_valid}, 32'd1);
    check_eq("bp_if_pc", if_pc, 32'h0000_000C);
    check_eq("bp_instr", if_instr, 32'h1111_000C);

    // 2/3: raising if_ready issues at once; ack arrives on the 4th request cycle
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'h2222_0010;
      end
      settle();
      check_eq($sformatf("dly_req%0d", i), {31'd0, imem_req}, 32'd1);
      check_eq($sformatf("dly_addr%0d", i), imem_addr, 32'h0000_0010);
      step();
      if (i < 3) check_eq($sformatf("dly_valid%0d", i), {31'd0, if_valid}, 32'd0);
    end
    check_eq("dly_valid", {31'd0, if_valid}, 32'd1);
    check_eq("dly_if_pc", if_pc, 32'h0000_0010);
    check_eq("dly_instr", if_instr, 32'h2222_0010);
    check_eq("dly_next_addr", imem_addr, 32'h0000_0014);

    // fetch 0x14..0x1C, then leave a request to 0x20 pending
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'h2222_0014 + 32'(i * 4);
      step();
      check_eq($sformatf("pre_if_pc%0d", i), if_pc, 32'h0000_0014 + 32'(i * 4));
    end
    imem_ack = 1'b0;
    settle();
    check_eq("pend_req", {31'd0, imem_req}, 32'd1);
    check_eq("pend_addr", imem_addr, 32'h0000_0020);
    step();

    // 4: redirect while pending -> drain, old data dropped
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check_eq("drn_valid", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq($sformatf("drn_req%0d", i), {31'd0, imem_req}, 32'd1);
      check_eq($sformatf("drn_addr%0d", i), imem_addr, 32'h0000_0020);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    check_eq("drn_drop_valid", {31'd0, if_valid}, 32'd0);
    imem_rdata = 32'h3333_0200;
    settle();
    check_eq("post_drn_req", {31'd0, imem_req}, 32'd1);
    check_eq("post_drn_addr", imem_addr, 32'h0000_0200);
    step();
    check_eq("post_drn_valid", {31'd0, if_valid}, 32'd1);
    check_eq("post_drn_if_pc", if_pc, 32'h0000_0200);
    check_eq("post_drn_instr", if_instr, 32'h3333_0200);

    // 5: redirect + ack, if_valid=1 & if_ready=0; low address bits forced to zero
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0302;
    settle();
    check_eq("rd_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    check_eq("rd_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rd_addr", imem_addr, 32'h0000_0300);
    if_ready = 1'b1; imem_rdata = 32'h4444_0300;
    settle();
    check_eq("rd_req2", {31'd0, imem_req}, 32'd1);
    step();
    check_eq("rd_if_pc", if_pc, 32'h0000_0300);
    check_eq("rd_instr", if_instr, 32'h4444_0300);

    // 6: wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_rdata = 32'h5555_FFFC;
    settle();
    check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("wrap_next", imem_addr, 32'h0000_0000);
    imem_rdata = 32'h6666_0000;
    step();
    check_eq("wrap_if_pc0", if_pc, 32'h0000_0000);
    imem_ack = 1'b0;
    step();
    settle();
    check_eq("mid_req", {31'd0, imem_req}, 32'd1);
    check_eq("mid_addr", imem_addr, 32'h0000_0004);

    // 6: reset while pending
    rst = 1'b1;
    settle();
    check_eq("mid_rst_req", {31'd0, imem_req}, 32'd0);
    step();
    check_eq("mid_rst_addr", imem_addr, 32'h0000_0000);
    check_eq("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("mid_rst_if_pc", if_pc, 32'd0);
    rst = 1'b0;
    settle();
    check_eq("post_rst_req", {31'd0, imem_req}, 32'd1);
    check_eq("post_rst_addr", imem_addr, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
